keypad_scan: RTL and testbench

//  Input-side counterpart of the board's 7-segment display driver: scans a 4x4 hex keypad, debounces it and reports key presses.

---
 rtl/keypad_pkg.sv | 44 ++++
 rtl/keypad_scan_if.sv | 29 ++
 rtl/keypad_col_seq.sv | 58 +++++
 rtl/keypad_scan.sv | 190 +++++++++++++++++++
 tb/tb_keypad_scan.sv | 215 +++++++++++++++++++++
 5 files changed

// File: rtl/keypad_pkg.sv
// Shared definitions for the 4x4 hex keypad scanner.
// Holds the one-hot-low column drive constants, the key FSM state encoding and
// the row/column to hex key-code map.
package keypad_pkg;

  // Column drive patterns, in scan order.
  localparam logic [3:0] ColN0 = 4'b1110;
  localparam logic [3:0] ColN1 = 4'b1101;
  localparam logic [3:0] ColN2 = 4'b1011;
  localparam logic [3:0] ColN3 = 4'b0111;

  typedef enum logic [1:0] {
    StIdle     = 2'd0,
    StDebounce = 2'd1,
    StPressed  = 2'd2
  } key_state_e;

  // Keypad layout:
  //   r0: 1 2 3 A | r1: 4 5 6 B | r2: 7 8 9 C | r3: E 0 F D
  function automatic logic [3:0] key_map(input logic [1:0] row, input logic [1:0] col);
    logic [3:0] code;
    unique case ({row, col})
      4'b00_00: code = 4'h1;
      4'b00_01: code = 4'h2;
      4'b00_10: code = 4'h3;
      4'b00_11: code = 4'hA;
      4'b01_00: code = 4'h4;
      4'b01_01: code = 4'h5;
      4'b01_10: code = 4'h6;
      4'b01_11: code = 4'hB;
      4'b10_00: code = 4'h7;
      4'b10_01: code = 4'h8;
      4'b10_10: code = 4'h9;
      4'b10_11: code = 4'hC;
      4'b11_00: code = 4'hE;
      4'b11_01: code = 4'h0;
      4'b11_10: code = 4'hF;
      4'b11_11: code = 4'hD;
      default:  code = 4'h0;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/keypad_scan_if.sv
// Key-event bus between the keypad scanner and its consumer (display logic).
//   key_code  : hex code of the last accepted key
//   key_valid : 1-cycle pulse per accepted key (and per auto-repeat, if enabled)
//   key_held  : high while the accepted key stays pressed
//   entry     : last four digits, newest in [3:0]
//   entry_clr : synchronous clear of entry, driven by the consumer
interface keypad_scan_if;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        key_held;
  logic [15:0] entry;
  logic        entry_clr;

  modport master (
    output key_code,
    output key_valid,
    output key_held,
    output entry,
    input  entry_clr
  );

  modport slave (
    input  key_code,
    input  key_valid,
    input  key_held,
    input  entry,
    output entry_clr
  );
endinterface

// File: rtl/keypad_col_seq.sv
// Column sequencer for the keypad scanner.
// Divides clk by SCAN_DIV into a column-step tick, rotates the active-low column
// drive 1110 -> 1101 -> 1011 -> 0111 on each tick, and flags the tick that ends a pass.
// Ports:
//   clk_i, reset_i : clock, synchronous active-high reset
//   col_n_o        : column drive, exactly one bit low
//   col_idx_o      : index of the currently driven column
//   tick_o         : terminal count of the divider (sample the current column)
//   pass_end_o     : tick on the last column of a pass
module keypad_col_seq
  import keypad_pkg::*;
#(
  parameter int unsigned SCAN_DIV = 10000
) (
  input  logic       clk_i,
  input  logic       reset_i,
  output logic [3:0] col_n_o,
  output logic [1:0] col_idx_o,
  output logic       tick_o,
  output logic       pass_end_o
);

  localparam int unsigned DivW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DivW-1:0] DivLast = DivW'(SCAN_DIV - 1);

  logic [DivW-1:0] div_q, div_d;
  logic [3:0]      col_n_q, col_n_d;

  always_comb begin
    tick_o  = (div_q == DivLast);
    div_d   = tick_o ? '0 : div_q + DivW'(1);
    col_n_d = tick_o ? {col_n_q[2:0], col_n_q[3]} : col_n_q;
  end

  always_comb begin
    unique case (col_n_q)
      ColN0:   col_idx_o = 2'd0;
      ColN1:   col_idx_o = 2'd1;
      ColN2:   col_idx_o = 2'd2;
      ColN3:   col_idx_o = 2'd3;
      default: col_idx_o = 2'd0;
    endcase
  end

  assign pass_end_o = tick_o && (col_n_q == ColN3);
  assign col_n_o    = col_n_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      div_q   <= '0;
      col_n_q <= ColN0;
    end else begin
      div_q   <= div_d;
      col_n_q <= col_n_d;
    end
  end

endmodule

// File: rtl/keypad_scan.sv
// 4x4 hex keypad scanner with debounce, multi-key rejection and a 4-digit entry register.
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   row_n      : keypad rows, active-low, asynchronous
//   col_n      : column drive, one bit low at a time
//   bus        : key event bus (key_code, key_valid, key_held, entry, entry_clr)
// Optional feature: define KEYPAD_AUTOREPEAT_EN to re-issue the held key every
// REPEAT_SCANS passes; without it no repeat logic exists.
module keypad_scan
  import keypad_pkg::*;
#(
  parameter int unsigned SCAN_DIV       = 10000,
  parameter int unsigned DEBOUNCE_SCANS = 4,
  parameter int unsigned REPEAT_SCANS   = 64
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [3:0]    row_n,
  output logic [3:0]    col_n,
  keypad_scan_if.master bus
);

  if (DEBOUNCE_SCANS < 1) begin : g_bad_debounce
    $error("DEBOUNCE_SCANS must be at least 1");
  end
  if (REPEAT_SCANS < 1) begin : g_bad_repeat
    $error("REPEAT_SCANS must be at least 1");
  end

  localparam int unsigned CntW = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [CntW-1:0] DebMax = CntW'(DEBOUNCE_SCANS);

  logic [1:0] col_idx;
  logic       tick, pass_end;

  keypad_col_seq #(
    .SCAN_DIV (SCAN_DIV)
  ) u_col_seq (
    .clk_i      (clk),
    .reset_i    (reset),
    .col_n_o    (col_n),
    .col_idx_o  (col_idx),
    .tick_o     (tick),
    .pass_end_o (pass_end)
  );

  logic [3:0]      row_s1_q, row_s2_q;
  // keys_q[c][r] = key at column c, row r seen pressed in this pass.
  logic [3:0][3:0] keys_q, keys_now;
  logic [4:0]      n_down;
  logic [3:0]      hit_code;
  logic            single, none;

  key_state_e    state_q;
  logic [3:0]    cand_q;
  logic [CntW-1:0] cnt_q, rel_cnt_q;
  logic          key_valid_q, key_held_q;
  logic [3:0]    key_code_q;
  logic [15:0]   entry_q;
`ifdef KEYPAD_AUTOREPEAT_EN
  localparam int unsigned RepW = $clog2(REPEAT_SCANS + 1);
  localparam logic [RepW-1:0] RepLast = RepW'(REPEAT_SCANS - 1);
  logic [RepW-1:0] rep_cnt_q;
`endif

  // The current column's sample is merged in so the pass-end tick evaluates a full pass.
  always_comb begin
    keys_now          = keys_q;
    keys_now[col_idx] = ~row_s2_q;
    n_down            = '0;
    hit_code          = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        if (keys_now[c][r]) begin
          n_down   = n_down + 5'd1;
          hit_code = key_map(2'(r), 2'(c));
        end
      end
    end
    single = (n_down == 5'd1);
    none   = (n_down == 5'd0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      row_s1_q    <= 4'hF;
      row_s2_q    <= 4'hF;
      keys_q      <= '0;
      state_q     <= StIdle;
      cand_q      <= '0;
      cnt_q       <= '0;
      rel_cnt_q   <= '0;
      key_valid_q <= 1'b0;
      key_held_q  <= 1'b0;
      key_code_q  <= '0;
      entry_q     <= '0;
`ifdef KEYPAD_AUTOREPEAT_EN
      rep_cnt_q   <= '0;
`endif
    end else begin
      row_s1_q    <= row_n;
      row_s2_q    <= row_s1_q;
      key_valid_q <= 1'b0;
      if (tick) keys_q <= keys_now;

      if (pass_end) begin
        unique case (state_q)
          StIdle: begin
            if (single) begin
              cand_q <= hit_code;
              if (DEBOUNCE_SCANS <= 1) begin
                state_q     <= StPressed;
                key_held_q  <= 1'b1;
                rel_cnt_q   <= '0;
                key_valid_q <= 1'b1;
                key_code_q  <= hit_code;
                entry_q     <= {entry_q[11:0], hit_code};
              end else begin
                state_q <= StDebounce;
                cnt_q   <= CntW'(1);
              end
            end
          end

          StDebounce: begin
            if (single && (hit_code == cand_q)) begin
              cnt_q <= cnt_q + CntW'(1);
              if (cnt_q + CntW'(1) == DebMax) begin
                state_q     <= StPressed;
                key_held_q  <= 1'b1;
                rel_cnt_q   <= '0;
                key_valid_q <= 1'b1;
                key_code_q  <= hit_code;
                entry_q     <= {entry_q[11:0], hit_code};
              end
            end else begin
              state_q <= StIdle;
              cnt_q   <= '0;
            end
          end

          StPressed: begin
            // Other keys and multi-presses are ignored here; only a clean release counts.
            if (none) begin
              if (rel_cnt_q + CntW'(1) == DebMax) begin
                state_q    <= StIdle;
                key_held_q <= 1'b0;
                rel_cnt_q  <= '0;
                cnt_q      <= '0;
              end else begin
                rel_cnt_q <= rel_cnt_q + CntW'(1);
              end
            end else begin
              rel_cnt_q <= '0;
            end
`ifdef KEYPAD_AUTOREPEAT_EN
            if (single && (hit_code == cand_q)) begin
              if (rep_cnt_q == RepLast) begin
                rep_cnt_q   <= '0;
                key_valid_q <= 1'b1;
                key_code_q  <= cand_q;
                entry_q     <= {entry_q[11:0], cand_q};
              end else begin
                rep_cnt_q <= rep_cnt_q + RepW'(1);
              end
            end else begin
              rep_cnt_q <= '0;
            end
`endif
          end

          default: state_q <= StIdle;
        endcase
      end

`ifdef KEYPAD_AUTOREPEAT_EN
      // Holding at zero outside PRESSED means the count starts fresh on every acceptance.
      if (state_q != StPressed) rep_cnt_q <= '0;
`endif
      // Last assignment wins: a clear coinciding with acceptance drops the digit.
      if (bus.entry_clr) entry_q <= '0;
    end
  end

  assign bus.key_code  = key_code_q;
  assign bus.key_valid = key_valid_q;
  assign bus.key_held  = key_held_q;
  assign bus.entry     = entry_q;

endmodule

// File: tb/tb_keypad_scan.sv
// Bench for keypad_scan: a physical keypad model pulls rows low for pressed keys in the
// driven column; a pass-level reference model predicts events, entry and key_held.
module tb_keypad_scan;

  localparam int unsigned ScanDiv = 4;
  localparam int unsigned Deb     = 2;
  localparam int unsigned Rep     = 3;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  row_n, col_n;
  logic [15:0] mask = '0;  // bit r*4+c set = key at row r, column c pressed

  keypad_scan_if bus ();

  keypad_scan #(
    .SCAN_DIV       (ScanDiv),
    .DEBOUNCE_SCANS (Deb),
    .REPEAT_SCANS   (Rep)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .row_n (row_n),
    .col_n (col_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always_comb begin
    row_n = 4'hF;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        if (!col_n[c] && mask[r*4+c]) row_n[r] = 1'b0;
  end

  logic [3:0] key_at [16] = '{4'h1, 4'h2, 4'h3, 4'hA, 4'h4, 4'h5, 4'h6, 4'hB,
                              4'h7, 4'h8, 4'h9, 4'hC, 4'hE, 4'h0, 4'hF, 4'hD};

  int n_checks = 0;
  int n_bad    = 0;
  int pulses   = 0;

  always @(posedge clk) if (!reset && bus.key_valid === 1'b1) pulses <= pulses + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model state, stepped once per scan pass.
  int          m_streak, m_rel, m_rep, m_events;
  logic [3:0]  m_cand, m_code;
  bit          m_held;
  logic [15:0] m_entry;

  task automatic model_reset();
    m_streak = 0; m_rel = 0; m_rep = 0;
    m_cand = '0; m_code = '0; m_held = 0; m_entry = '0;
  endtask

  task automatic check_idle_outputs(input string tag);
    check_eq({tag, "_col"}, col_n, 4'b1110);
    check_eq({tag, "_valid"}, bus.key_valid, 1'b0);
    check_eq({tag, "_code"}, bus.key_code, 4'h0);
    check_eq({tag, "_entry"}, bus.entry, 16'h0);
    check_eq({tag, "_held"}, bus.key_held, 1'b0);
  endtask

  // One full scan pass with a fixed pressed-key set; clr asserts entry_clr in the
  // cycle whose closing edge ends the pass.
  task automatic run_pass(input logic [15:0] keys, input bit clr);
    logic [3:0] exp_col;
    logic [3:0] k;
    int         n;
    bit         ev;
    mask    = keys;
    exp_col = 4'b1110;
    for (int c = 0; c < 4; c++) begin
      check_eq("col_n", col_n, exp_col);
      exp_col = {exp_col[2:0], exp_col[3]};
      repeat (ScanDiv - 1) @(posedge clk);
      #1;
      if (c == 3) bus.entry_clr = clr;
      @(posedge clk);
      #1;
      bus.entry_clr = 1'b0;
    end

    n = $countones(keys);
    k = '0;
    for (int p = 0; p < 16; p++) if (keys[p]) k = key_at[p];
    ev = 0;
    if (!m_held) begin
      if (n == 1 && m_streak > 0 && k == m_cand) m_streak++;
      else if (n == 1 && m_streak == 0) begin
        m_cand   = k;
        m_streak = 1;
      end else m_streak = 0;
      if (m_streak >= Deb) begin
        ev = 1; m_held = 1; m_rel = 0; m_rep = 0; m_streak = 0;
      end
    end else begin
      if (n == 0) m_rel++;
      else m_rel = 0;
`ifdef KEYPAD_AUTOREPEAT_EN
      if (n == 1 && k == m_cand) begin
        m_rep++;
        if (m_rep == Rep) begin
          ev    = 1;
          m_rep = 0;
        end
      end else m_rep = 0;
`endif
      if (m_rel == Deb) begin
        m_held = 0;
        m_rel  = 0;
      end
    end
    if (ev) begin
      m_code  = m_cand;
      m_entry = {m_entry[11:0], m_cand};
      m_events++;
    end
    if (clr) m_entry = '0;

    check_eq("key_valid", bus.key_valid, ev);
    check_eq("key_code", bus.key_code, m_code);
    check_eq("entry", bus.entry, m_entry);
    check_eq("key_held", bus.key_held, m_held);
  endtask

  task automatic hold(input logic [15:0] keys, input int passes);
    for (int i = 0; i < passes; i++) run_pass(keys, 1'b0);
  endtask

  initial begin
    logic [15:0] keys;
    int          kind, np;
    bus.entry_clr = 1'b0;
    m_events = 0;
    model_reset();

    repeat (3) @(posedge clk);
    #1;
    check_idle_outputs("reset");
    reset = 1'b0;

    // Idle scanning.
    hold(16'h0000, 2);

    // Key 6 (r1/c2) for 3 passes, then release.
    hold(16'h0001 << 6, 3);
    check_eq("key6_entry", bus.entry, 16'h0006);
    hold(16'h0000, 2);

    // 1, 2, 3, A in sequence.
    for (int p = 0; p < 4; p++) begin
      hold(16'h0001 << p, 2);
      hold(16'h0000, 2);
    end
    check_eq("seq_entry", bus.entry, 16'h123A);

    // Key 5 bouncing every pass.
    for (int i = 0; i < 6; i++) run_pass((i % 2 == 0) ? (16'h0001 << 5) : 16'h0000, 1'b0);

    // Keys 1 and 9 together, then release 9.
    hold((16'h0001 << 0) | (16'h0001 << 10), 3);
    hold(16'h0001 << 0, 3);
    check_eq("multi_code", bus.key_code, 4'h1);
    hold(16'h0000, 2);

    // Key 7 with entry_clr coinciding with acceptance, then held long.
    run_pass(16'h0001 << 8, 1'b0);
    run_pass(16'h0001 << 8, 1'b1);
    check_eq("clr_entry", bus.entry, 16'h0000);
    check_eq("clr_code", bus.key_code, 4'h7);
    hold(16'h0001 << 8, 7);
    hold(16'h0000, 2);

    // Reset in the middle of a pass with a key down.
    mask = 16'h0001 << 4;
    repeat (7) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    mask = '0;
    check_idle_outputs("midreset");
    model_reset();
    reset = 1'b0;

    // Random segments: idle, single keys, and two-key presses.
    for (int s = 0; s < 50; s++) begin
      kind = $urandom_range(0, 9);
      np   = $urandom_range(1, 4);
      keys = '0;
      if (kind >= 4) keys[$urandom_range(0, 15)] = 1'b1;
      if (kind == 9) keys[$urandom_range(0, 15)] = 1'b1;
      for (int i = 0; i < np; i++) run_pass(keys, ($urandom_range(0, 15) == 0));
    end

    hold(16'h0000, 3);
    @(posedge clk);
    #1;
    check_eq("pulse_count", pulses, m_events);

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
